pipe_ctl_fsm: RTL



---
 rtl/mips789_ctl_pkg.sv | 42 ++++
 rtl/pipe_ctl_fsm_if.sv | 42 ++++
 rtl/irq_prio_enc.sv | 21 ++
 rtl/pipe_ctl_fsm.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mips789_ctl_pkg.sv
// mips789_ctl_pkg: state, id_cmd and PC-select encodings shared by
// the pipeline control FSM, its bus interface and sub-blocks.
// Optional divide stall state is present only with CTL_DIV_EN.
package mips789_ctl_pkg;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_IDLE = 4'd1,
    S_NOI  = 4'd2,
    S_CUR  = 4'd3,
    S_MUL  = 4'd4,
`ifdef CTL_DIV_EN
    S_DIV  = 4'd5,
`endif
    S_LD   = 4'd6,
    S_IRQ  = 4'd7,
    S_RET  = 4'd8
  } state_e;

  localparam logic [2:0] CMD_NONE = 3'd0;
  localparam logic [2:0] CMD_NOI  = 3'd1;
  localparam logic [2:0] CMD_CUR  = 3'd2;
  localparam logic [2:0] CMD_MUL  = 3'd3;
  localparam logic [2:0] CMD_LD   = 3'd4;
  localparam logic [2:0] CMD_RET  = 3'd5;
  localparam logic [2:0] CMD_DIV  = 3'd6;

  localparam logic [3:0] PC_IGN = 4'b0001;
  localparam logic [3:0] PC_KEP = 4'b0010;
  localparam logic [3:0] PC_IRQ = 4'b0100;
  localparam logic [3:0] PC_RST = 4'b1000;

  // Width of an index into n sources, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_ctl_fsm_if.sv
// pipe_ctl_fsm_if: decode-side inputs (pause, id_cmd, irq, irq_mask)
// and control outputs (iack, irq_id, busy, nop, clr/cls, pc_prectl).
interface pipe_ctl_fsm_if #(
  parameter int IRQ_N = 4
);
  import mips789_ctl_pkg::*;

  localparam int IDW = idx_w(IRQ_N);

  logic             pause;
  logic [2:0]       id_cmd;
  logic [IRQ_N-1:0] irq;
  logic [IRQ_N-1:0] irq_mask;

  logic             iack;
  logic [IDW-1:0]   irq_id;
  logic             busy;
  logic             zz_is_nop;
  logic             id2ra_ins_clr;
  logic             id2ra_ins_cls;
  logic             id2ra_ctl_clr;
  logic             id2ra_ctl_cls;
  logic             ra2exec_ctl_clr;
  logic [3:0]       pc_prectl;

  modport master (
    output pause, id_cmd, irq, irq_mask,
    input  iack, irq_id, busy, zz_is_nop,
    input  id2ra_ins_clr, id2ra_ins_cls,
    input  id2ra_ctl_clr, id2ra_ctl_cls,
    input  ra2exec_ctl_clr, pc_prectl
  );

  modport slave (
    input  pause, id_cmd, irq, irq_mask,
    output iack, irq_id, busy, zz_is_nop,
    output id2ra_ins_clr, id2ra_ins_cls,
    output id2ra_ctl_clr, id2ra_ctl_cls,
    output ra2exec_ctl_clr, pc_prectl
  );

endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: masked-request priority encoder, lowest index wins.
// Ports: req (N) in; valid (any request), idx (W) winning index out.
module irq_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  // Scan high to low so the lowest set bit is written last.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/pipe_ctl_fsm.sv
// pipe_ctl_fsm: mips789 hazard/stall/interrupt controller driving
// pipeline-register clr/cls and PC-next select. Ports: clk, rst
// (sync, active-low), bus (pipe_ctl_fsm_if.slave). Macro: CTL_DIV_EN.
module pipe_ctl_fsm
  import mips789_ctl_pkg::*;
#(
  parameter int MUL_LAT = 33,
  parameter int DIV_LAT = 34,
  parameter int LD_LAT  = 1,
  parameter int IRQ_N   = 4
) (
  input  logic           clk,
  input  logic           rst,
  pipe_ctl_fsm_if.slave  bus
);

  localparam int IDW = idx_w(IRQ_N);

`ifdef CTL_DIV_EN
  localparam int MAX_LAT =
    max2(max2(MUL_LAT, LD_LAT), DIV_LAT);
`else
  localparam int MAX_LAT = max2(MUL_LAT, LD_LAT);
`endif

  localparam int CW = $clog2(MAX_LAT + 1);

  localparam logic [CW-1:0] MUL_END = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] LD_END  = CW'(LD_LAT - 1);
`ifdef CTL_DIV_EN
  localparam logic [CW-1:0] DIV_END = CW'(DIV_LAT - 1);
`else
  // Divide latency has no effect without the divider.
  logic unused_div_lat;
  assign unused_div_lat = ^DIV_LAT;
`endif

  state_e         state, state_n;
  state_e         cmd_st;
  logic [CW-1:0]  cnt, cnt_n;
  logic [CW-1:0]  lat_end;
  logic           iack, iack_n;
  logic [IDW-1:0] irq_id, irq_id_n;
  logic           pend;
  logic [IDW-1:0] pend_idx;
  logic           take;

  irq_prio_enc #(
    .N (IRQ_N),
    .W (IDW)
  ) u_enc (
    .req   (bus.irq & bus.irq_mask),
    .valid (pend),
    .idx   (pend_idx)
  );

  // An interrupt already in service blocks new ones until RET.
  assign take = ~iack & pend;

  always_comb begin
    cmd_st = S_IDLE;
    unique case (1'b1)
      bus.id_cmd == CMD_NOI: cmd_st = S_NOI;
      bus.id_cmd == CMD_CUR: cmd_st = S_CUR;
      bus.id_cmd == CMD_MUL: cmd_st = S_MUL;
      bus.id_cmd == CMD_LD:  cmd_st = S_LD;
      bus.id_cmd == CMD_RET: cmd_st = S_RET;
`ifdef CTL_DIV_EN
      bus.id_cmd == CMD_DIV: cmd_st = S_DIV;
`endif
      default:               cmd_st = S_IDLE;
    endcase
  end

  always_comb begin
    lat_end = '0;
    case (state)
      S_MUL:   lat_end = MUL_END;
      S_LD:    lat_end = LD_END;
`ifdef CTL_DIV_EN
      S_DIV:   lat_end = DIV_END;
`endif
      default: lat_end = '0;
    endcase
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    iack_n   = iack;
    irq_id_n = irq_id;
    if (!bus.pause) begin
      case (state)
        S_IDLE, S_NOI: begin
          if (take) begin
            state_n  = S_IRQ;
            iack_n   = 1'b1;
            irq_id_n = pend_idx;
          end else begin
            state_n = cmd_st;
            if (cmd_st == S_RET) iack_n = 1'b0;
          end
        end
        S_CUR: state_n = S_NOI;
`ifdef CTL_DIV_EN
        S_MUL, S_LD, S_DIV: begin
`else
        S_MUL, S_LD: begin
`endif
          if (cnt == lat_end) begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_IRQ, S_RET: state_n = S_IDLE;
        S_RST: begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
        default: begin
          state_n = S_RST;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_RST;
      cnt    <= '0;
      iack   <= 1'b0;
      irq_id <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      iack   <= iack_n;
      irq_id <= irq_id_n;
    end
  end

  assign bus.iack   = iack;
  assign bus.irq_id = irq_id;

  always_comb begin
    bus.busy            = 1'b0;
    bus.zz_is_nop       = 1'b0;
    bus.id2ra_ins_clr   = 1'b0;
    bus.id2ra_ins_cls   = 1'b0;
    bus.id2ra_ctl_clr   = 1'b0;
    bus.id2ra_ctl_cls   = 1'b0;
    bus.ra2exec_ctl_clr = 1'b0;
    bus.pc_prectl       = PC_IGN;
    case (state)
      S_IDLE, S_NOI, S_RET: ;
`ifdef CTL_DIV_EN
      S_MUL, S_LD, S_DIV: begin
`else
      S_MUL, S_LD: begin
`endif
        bus.busy          = 1'b1;
        bus.id2ra_ins_clr = 1'b1;
        bus.id2ra_ctl_clr = 1'b1;
        bus.pc_prectl     = PC_KEP;
      end
      S_CUR: begin
        bus.id2ra_ins_cls   = 1'b1;
        bus.id2ra_ctl_cls   = 1'b1;
        bus.ra2exec_ctl_clr = 1'b1;
        bus.zz_is_nop       = 1'b1;
        bus.pc_prectl       = PC_KEP;
      end
      S_IRQ: begin
        bus.id2ra_ins_clr   = 1'b1;
        bus.id2ra_ctl_clr   = 1'b1;
        bus.ra2exec_ctl_clr = 1'b1;
        bus.pc_prectl       = PC_IRQ;
      end
      default: begin
        bus.id2ra_ins_clr   = 1'b1;
        bus.id2ra_ctl_clr   = 1'b1;
        bus.ra2exec_ctl_clr = 1'b1;
        bus.zz_is_nop       = 1'b1;
        bus.pc_prectl       = PC_RST;
      end
    endcase
  end

endmodule
